// File: rtl/bus_src_arbiter_if.sv
// Request/grant bundle between the control unit and the bus source arbiter.
interface bus_src_arbiter_if #(
  parameter int N_SRC = 16,
  parameter int SEL_W = 4
);
  logic [N_SRC-1:0] req;
  logic             xfer_done;
  logic [SEL_W-1:0] sel;
  logic             grant_valid;
  logic [N_SRC-1:0] grant_onehot;
  logic             timeout_err;
  logic             proto_err;

  // Control-unit side: raises requests and signals completed transfers.
  modport master (
    output req, xfer_done,
    input  sel, grant_valid, grant_onehot, timeout_err, proto_err
  );

  // Arbiter side: drives the bus mux select and status pulses.
  modport slave (
    input  req, xfer_done,
    output sel, grant_valid, grant_onehot, timeout_err, proto_err
  );
endinterface

// File: rtl/bus_src_arbiter.sv
// Round-robin arbiter driving the 16:1 bus mux select. A grant is held until
// the consumer reports xfer_done, the requester withdraws, or the grant ages out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no live grant; sel holds its previous value
// S_GRANT | sel is driving the bus, waiting for xfer_done
module bus_src_arbiter #(
  parameter int N_SRC   = 16,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  bus_src_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel,  w_sel_nxt;
  logic [SEL_W-1:0] r_last, w_last_nxt;
  logic [7:0]       r_cnt,  w_cnt_nxt;
  logic             r_gv,   w_gv_nxt;
  logic [N_SRC-1:0] r_onehot, w_onehot_nxt;
  logic             r_tout, w_tout_nxt;
  logic             r_perr, w_perr_nxt;

  logic             w_any_req;
  logic             w_req_sel;
  logic             w_timeout;
  logic [SEL_W-1:0] w_base;
  logic [SEL_W-1:0] w_pick;

  // First set request after 'last', wrapping; the descending scan lets the
  // nearest candidate overwrite farther ones. Wrap relies on N_SRC == 2**SEL_W.
  function automatic logic [SEL_W-1:0] f_pick(input logic [N_SRC-1:0] req,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    pick = last;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign w_any_req = |bus.req;
  assign w_req_sel = bus.req[r_sel];
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  // A completed transfer moves the pointer before re-arbitration.
  assign w_base    = (r_state == S_GRANT && bus.xfer_done) ? r_sel : r_last;
  assign w_pick    = f_pick(bus.req, w_base);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decision; xfer_done outranks both withdrawal and timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_GRANT;
      S_GRANT: begin
        if (bus.xfer_done || !w_req_sel)
          w_state_nxt = w_any_req ? S_GRANT : S_IDLE;
        else if (w_timeout)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and age counter.
  always_comb begin
    w_sel_nxt  = r_sel;
    w_last_nxt = r_last;
    w_cnt_nxt  = r_cnt;
    w_tout_nxt = 1'b0;
    w_perr_nxt = bus.xfer_done & ~r_gv;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_sel_nxt = w_pick;
          w_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (bus.xfer_done) begin
          w_last_nxt = r_sel;
          if (w_any_req) begin
            w_sel_nxt = w_pick;
            w_cnt_nxt = '0;
          end
        end else if (!w_req_sel) begin
          if (w_any_req) begin
            w_sel_nxt = w_pick;
            w_cnt_nxt = '0;
          end
        end else if (w_timeout) begin
          w_tout_nxt = 1'b1;
          w_last_nxt = r_sel;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    w_gv_nxt     = (w_state_nxt == S_GRANT);
    w_onehot_nxt = w_gv_nxt ? (N_SRC'(1) << w_sel_nxt) : '0;
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel    <= '0;
      r_last   <= SEL_W'(N_SRC - 1);
      r_cnt    <= '0;
      r_gv     <= 1'b0;
      r_onehot <= '0;
      r_tout   <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_sel    <= w_sel_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gv     <= w_gv_nxt;
      r_onehot <= w_onehot_nxt;
      r_tout   <= w_tout_nxt;
      r_perr   <= w_perr_nxt;
    end
  end

  assign bus.sel          = r_sel;
  assign bus.grant_valid  = r_gv;
  assign bus.grant_onehot = r_onehot;
  assign bus.timeout_err  = r_tout;
  assign bus.proto_err    = r_perr;

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Bench for bus_src_arbiter: directed vector table, hand sequences for
// timeout and reset, then random traffic against a behavioural model.
module tb_bus_src_arbiter;
  localparam int N = 16;
  localparam int TO = 15;

  logic clk;
  logic rst;
  bus_src_arbiter_if #(.N_SRC(N), .SEL_W(4)) bus ();

  bus_src_arbiter #(.N_SRC(N), .SEL_W(4), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        xd;
    logic [3:0]  sel;
    logic        gv;
    logic        tout;
    logic        perr;
  } vec_t;

  vec_t tbl [18];

  // Behavioural model: who holds the bus, who was served last, grant age.
  bit       m_busy;
  int       m_sel, m_last, m_age;
  bit       m_tout, m_perr;

  function automatic int rr_pick(input logic [15:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  task automatic model_step(input logic r, input logic [15:0] req, input logic xd);
    if (r) begin
      m_busy = 0; m_sel = 0; m_last = N - 1; m_age = 0; m_tout = 0; m_perr = 0;
      return;
    end
    m_perr = xd && !m_busy;
    m_tout = 0;
    if (!m_busy) begin
      if (req != 0) begin m_sel = rr_pick(req, m_last); m_busy = 1; m_age = 0; end
    end else if (xd) begin
      m_last = m_sel;
      if (req != 0) begin m_sel = rr_pick(req, m_last); m_age = 0; end
      else m_busy = 0;
    end else if (!req[m_sel]) begin
      if (req != 0) begin m_sel = rr_pick(req, m_last); m_age = 0; end
      else m_busy = 0;
    end else if (m_age + 1 == TO) begin
      m_tout = 1; m_last = m_sel; m_busy = 0; m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] req, input logic xd);
    @(negedge clk);
    rst = r;
    bus.req = req;
    bus.xfer_done = xd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] sel, input logic gv,
                            input logic tout, input logic perr);
    logic [15:0] oh;
    oh = gv ? (16'd1 << sel) : 16'd0;
    chk({name, ".sel"},  32'(bus.sel), 32'(sel));
    chk({name, ".gv"},   32'(bus.grant_valid), 32'(gv));
    chk({name, ".oh"},   32'(bus.grant_onehot), 32'(oh));
    chk({name, ".tout"}, 32'(bus.timeout_err), 32'(tout));
    chk({name, ".perr"}, 32'(bus.proto_err), 32'(perr));
  endtask

  initial begin
    logic [15:0] rq;
    logic        xd, rr;
    rst = 1'b1;
    bus.req = '0;
    bus.xfer_done = 1'b0;

    //              rst  req       xd   sel gv tout perr
    tbl[0]  = '{1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0001, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h8101, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h8101, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h8101, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h8101, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0010, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 16'h0220, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'h0200, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 16'h0420, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].xd);
      expect_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gv, tbl[i].tout, tbl[i].perr);
    end

    // Stuck requester on source 3 ages out after 15 granted cycles.
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0008, 1'b0);
    expect_out("to_grant", 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 16'h0008, 1'b0);
      expect_out($sformatf("to_hold%0d", i), 4'd3, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 16'h0008, 1'b0);
    expect_out("to_fire", 4'd3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0018, 1'b0);
    expect_out("to_next", 4'd4, 1'b1, 1'b0, 1'b0);
    // xfer_done on the would-be timeout cycle completes instead.
    for (int i = 0; i < TO - 1; i++) step(1'b0, 16'h0018, 1'b0);
    expect_out("to_edge_hold", 4'd4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    expect_out("to_xd_wins", 4'd4, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    step(1'b0, 16'hFFFF, 1'b0);
    expect_out("rst_pre", 4'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    expect_out("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 1'b0);
    expect_out("rst_after", 4'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic against the model; requests are sticky so timeouts occur.
    step(1'b1, 16'h0000, 1'b0);
    model_step(1'b1, 16'h0000, 1'b0);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) rq = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rq = rq & 16'($urandom);
      xd = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 199) == 0);
      step(rr, rq, xd);
      model_step(rr, rq, xd);
      expect_out($sformatf("rnd%0d", c), 4'(m_sel), m_busy, m_tout, m_perr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
